// File: rtl/load_store_unit.sv
// Load/store initiator for the word-wide data_memory; sub-word stores go through read-modify-write.
// Optional request checking (misalignment, reserved size, range) is enabled by defining LSU_ERR_CHECK_EN.
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        memory_we,
    output logic [31:0] memory_address,
    output logic [31:0] memory_write_data,
    input  logic [31:0] memory_read_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, RMW_READ, RESP} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rmw_q, rmw_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic        req_err;
    logic        is_word, is_half;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;
    logic [31:0] store_word;

`ifdef LSU_ERR_CHECK_EN
    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);
    always_comb begin
        req_err = (req_size == 2'b11)
               || (req_size == 2'b01 && req_address[0])
               || (req_size == 2'b10 && req_address[1:0] != 2'b00)
               || (req_address >= ADDR_LIMIT);
    end
`else
    assign req_err = 1'b0;
`endif

    // size 11 only reaches ACCESS when unchecked, where it behaves as a word
    assign is_word = size_q[1];
    assign is_half = (size_q == 2'b01);

    assign byte_lane = memory_read_data[8*addr_q[1:0] +: 8];
    assign half_lane = addr_q[1] ? memory_read_data[31:16] : memory_read_data[15:0];

    always_comb begin
        if (is_word)
            load_data = memory_read_data;
        else if (is_half)
            load_data = {{16{~unsigned_q & half_lane[15]}}, half_lane};
        else
            load_data = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
    end

    // merge the new lane into the word captured during RMW_READ
    always_comb begin
        store_word = rmw_q;
        if (is_word)
            store_word = wdata_q;
        else if (is_half) begin
            if (addr_q[1])
                store_word[31:16] = wdata_q[15:0];
            else
                store_word[15:0] = wdata_q[15:0];
        end else
            store_word[8*addr_q[1:0] +: 8] = wdata_q[7:0];
    end

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rmw_d      = rmw_q;
        rdata_d    = rdata_q;
        error_d    = error_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_address;
                    wdata_d    = req_wdata;
                    if (req_err) begin
                        error_d = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else if (!req_write || req_size[1])
                        state_d = ACCESS;
                    else
                        state_d = RMW_READ;
                end
            end
            RMW_READ: begin
                rmw_d   = memory_read_data;
                state_d = ACCESS;
            end
            ACCESS: begin
                rdata_d = write_q ? 32'd0 : load_data;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    rdata_d = '0;
                    error_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rmw_q      <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rmw_q      <= rmw_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
        end
    end

    // write enable is a pure state decode so an async reset kills it immediately
    assign memory_we         = (state_q == ACCESS) && write_q;
    assign memory_address    = {addr_q[31:2], 2'b00};
    assign memory_write_data = memory_we ? store_word : 32'd0;
    assign req_ready         = (state_q == IDLE);
    assign resp_valid        = (state_q == RESP);
    assign resp_rdata        = rdata_q;
    assign resp_error        = error_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a word-array memory model predicts every response,
// memory cycle and latency; a negedge process compares the DUT each cycle.
module tb_load_store_unit;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_address, req_wdata;
    logic        resp_valid, resp_ready, resp_error;
    logic [31:0] resp_rdata;
    logic        memory_we;
    logic [31:0] memory_address, memory_write_data, memory_read_data;

    always #5 clock = ~clock;

    load_store_unit #(.MEM_WORDS(64)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error), .memory_we(memory_we),
        .memory_address(memory_address), .memory_write_data(memory_write_data),
        .memory_read_data(memory_read_data)
    );

    // data_memory stand-in; out-of-range reads return an address-derived pattern
    logic [31:0] mem [64];
    logic        mem_clr;
    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
        end else if (memory_we && memory_address < 32'd256)
            mem[memory_address[7:2]] <= memory_write_data;
    end
    always_comb begin
        memory_read_data = (memory_address < 32'd256) ? mem[memory_address[7:2]]
                                                       : (memory_address ^ 32'hA5A55A5A);
    end

    // reference model state
    logic [31:0] mmem [64];
    int          checks = 0, errors = 0;
    bit          txn_active = 0;
    int          edges = 0, t_lat = 0;
    bit          t_err = 0, t_store = 0;
    logic [31:0] t_rdata = 0, t_wd = 0, t_al = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mrd(input logic [31:0] a);
        logic [31:0] al;
        al = {a[31:2], 2'b00};
        return (al < 32'd256) ? mmem[al[7:2]] : (al ^ 32'hA5A55A5A);
    endfunction

    always @(negedge clock) begin
        if (!reset_n) begin
            chk("rst_req_ready", 32'(req_ready), 32'd1);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_resp_rdata", resp_rdata, 32'd0);
            chk("rst_resp_error", 32'(resp_error), 32'd0);
            chk("rst_memory_we", 32'(memory_we), 32'd0);
            chk("rst_memory_address", memory_address, 32'd0);
            chk("rst_memory_write_data", memory_write_data, 32'd0);
        end else if (!txn_active) begin
            chk("idle_req_ready", 32'(req_ready), 32'd1);
            chk("idle_resp_valid", 32'(resp_valid), 32'd0);
            chk("idle_resp_rdata", resp_rdata, 32'd0);
            chk("idle_resp_error", 32'(resp_error), 32'd0);
            chk("idle_memory_we", 32'(memory_we), 32'd0);
        end else begin
            chk("busy_req_ready", 32'(req_ready), 32'd0);
            chk("resp_valid", 32'(resp_valid), 32'(edges >= t_lat));
            if (edges >= t_lat) begin
                chk("resp_rdata", resp_rdata, t_rdata);
                chk("resp_error", 32'(resp_error), 32'(t_err));
            end
            chk("memory_we", 32'(memory_we), 32'(t_store && edges == t_lat - 1));
            if (!t_err && edges == t_lat - 1) begin
                chk("memory_address", memory_address, t_al);
                if (t_store) chk("memory_write_data", memory_write_data, t_wd);
            end
        end
    end

    task automatic scramble();
        req_valid    = 1'b1;
        req_write    = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_address  = $urandom;
        req_wdata    = $urandom;
    endtask

    // entered and left at posedge+1 with the DUT idle
    task automatic run_txn(input bit w, input logic [1:0] sz, input bit u,
                           input logic [31:0] a, input logic [31:0] wd, input int hold,
                           input bit lit_en, input logic [31:0] lit);
        logic [31:0] old, v, m;
        logic [1:0]  es;
        bit          err;
        int          sh;
        int          lat;
        err = 0;
`ifdef LSU_ERR_CHECK_EN
        err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
           || (a >= 32'd256);
`endif
        es  = (sz == 2'b11) ? 2'b10 : sz;
        old = mrd(a);
        sh  = (es == 2'b01) ? 16 * int'(a[1]) : 8 * int'(a[1:0]);
        m   = (es == 2'b01) ? (32'h0000FFFF << sh) : (32'h000000FF << sh);
        v   = 32'd0;
        if (err) lat = 1;
        else if (!w) begin
            lat = 2;
            if (es == 2'b10) v = old;
            else begin
                v = (old & m) >> sh;
                if (!u && es == 2'b01 && v[15]) v = v | 32'hFFFF0000;
                if (!u && es == 2'b00 && v[7])  v = v | 32'hFFFFFF00;
            end
        end else lat = (es == 2'b10) ? 2 : 3;

        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_address = a; req_wdata = wd;
        @(posedge clock); #1;
        t_lat   = lat;
        t_err   = err;
        t_store = w && !err;
        t_rdata = v;
        t_al    = {a[31:2], 2'b00};
        t_wd    = (es == 2'b10) ? wd : ((old & ~m) | ((wd << sh) & m));
        edges   = 1;
        txn_active = 1;
        scramble();
        while (edges < t_lat) begin
            @(posedge clock); #1;
            edges++;
            scramble();
        end
        if (lit_en) begin
            chk("lit_rdata", resp_rdata, lit);
            chk("lit_model", t_rdata, lit);
        end
        repeat (hold) begin
            @(posedge clock); #1;
            edges++;
            scramble();
        end
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        txn_active = 0;
        if (t_store && t_al < 32'd256) mmem[t_al[7:2]] = t_wd;
    endtask

    initial begin
        req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
        req_address = 0; req_wdata = 0; resp_ready = 0; mem_clr = 1;
        for (int i = 0; i < 64; i++) mmem[i] = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        mem_clr = 1'b0;

        run_txn(1, 2'b10, 0, 32'h0, 32'd100, 0, 0, 0);
        run_txn(1, 2'b10, 0, 32'h4, 32'd200, 1, 0, 0);
        run_txn(1, 2'b10, 0, 32'h8, 32'h11223344, 0, 0, 0);
        run_txn(0, 2'b10, 0, 32'h0, 32'h0, 0, 1, 32'd100);
        run_txn(1, 2'b00, 0, 32'h5, 32'h123456AB, 2, 0, 0);
        chk("sb_word", mem[1], 32'h0000ABC8);
        chk("sb_model_word", mmem[1], 32'h0000ABC8);
        run_txn(0, 2'b00, 0, 32'h5, 32'h0, 0, 1, 32'hFFFFFFAB);
        run_txn(0, 2'b00, 1, 32'h5, 32'h0, 0, 1, 32'h000000AB);
        run_txn(0, 2'b01, 0, 32'h4, 32'h0, 0, 1, 32'hFFFFABC8);
`ifdef LSU_ERR_CHECK_EN
        run_txn(0, 2'b01, 0, 32'h3, 32'h0, 0, 1, 32'h0);
        run_txn(0, 2'b10, 0, 32'h100, 32'h0, 0, 1, 32'h0);
        run_txn(1, 2'b11, 0, 32'h8, 32'hDEADBEEF, 0, 1, 32'h0);
`else
        run_txn(1, 2'b10, 0, 32'h0, 32'hFEDC0064, 0, 0, 0);
        run_txn(0, 2'b01, 0, 32'h3, 32'h0, 0, 1, 32'hFFFFFEDC);
        run_txn(0, 2'b11, 1, 32'h6, 32'h0, 0, 1, 32'h0000ABC8);
`endif
        run_txn(0, 2'b10, 0, 32'h4, 32'h0, 5, 1, 32'h0000ABC8);

        // reset while the SH is in its read half
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_address = 32'h8; req_wdata = 32'h0000BEEF;
        @(posedge clock); #1;
        req_valid = 1'b0;
        reset_n = 1'b0;
        @(posedge clock);
        @(posedge clock); #1;
        reset_n = 1'b1;
        chk("rst_word_kept", mem[2], 32'h11223344);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(256, 4095))
                                            : 32'($urandom_range(0, 255));
            run_txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                    $urandom_range(0, 3), 0, 0);
        end

        for (int i = 0; i < 64; i++) chk("final_mem_word", mem[i], mmem[i]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
